// File: rtl/tasks_parameters.sv
// Shared types and the per-task TV geometry table for task_sequencer.
// Task numbers run 1..32; index 0 of the hardware maps to task 1.
package tasks_parameters;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RUN,
        S_NEXT,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic [15:0] tv_in_bytes;
        logic [15:0] tv_in_num_transactions;
        logic [15:0] tv_out_num_transactions;
    } task_params_t;

    localparam int MAX_TASKS = 32;

    localparam task_params_t P_IN8_OUT2 = '{16'd8, 16'd2, 16'd2};
    localparam task_params_t P_IN4_OUT4 = '{16'd4, 16'd1, 16'd4};
    localparam task_params_t P_IN0_OUT4 = '{16'd0, 16'd0, 16'd4};
    localparam task_params_t P_IN4_OUT1 = '{16'd4, 16'd1, 16'd1};

    localparam task_params_t tasks_params_array [1:MAX_TASKS] = '{
        1:       P_IN8_OUT2,
        3:       P_IN8_OUT2,
        4:       P_IN4_OUT4,
        5:       P_IN0_OUT4,
        default: P_IN4_OUT1
    };

    function automatic task_params_t params_of(input logic [4:0] idx);
        logic [5:0] num;
        num = {1'b0, idx} + 6'd1;
        return tasks_params_array[num];
    endfunction

endpackage

// File: rtl/task_select_pe.sv
// Lowest-set-bit priority encoder; task_num is bit index + 1.
// found is low when no request bit is set.
module task_select_pe #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    output logic [4:0]   task_num,
    output logic         found
);

    always_comb begin
        task_num = '0;
        found    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                task_num = 5'(i + 1);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/task_sequencer.sv
// Runs every enabled task in ascending order: TV_IN requests,
// byte streaming into the task, answer writes to TV_OUT, watchdog.
module task_sequencer
    import tasks_parameters::*;
#(
    parameter int                NUM_TASKS     = 16,
    parameter int                DIN_W         = 8,
    parameter int                DOUT_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] TV_IN_BASE    = 'hA000_0000,
    parameter logic [ADDR_W-1:0] TV_OUT_BASE   = 'hA000_0800,
    parameter logic [ADDR_W-1:0] TV_OUT_STRIDE = 'h100,
    parameter int                TIMEOUT       = 65536,
    parameter int                CNT_W         = 12
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        start,
    input  logic [NUM_TASKS-1:0]        task_mask,
    output logic                        busy,
    output logic                        done,
    output logic [4:0]                  cur_task,
    output logic [NUM_TASKS-1:0]        done_mask,
    output logic [NUM_TASKS-1:0]        timeout_mask,
    output logic [ADDR_W-1:0]           req_addr,
    output logic                        req_valid,
    input  logic                        req_ready,
    input  logic [DIN_W-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DIN_W-1:0]            task_din,
    output logic [NUM_TASKS-1:0]        task_din_valid,
    output logic                        task_din_last,
    input  logic [NUM_TASKS-1:0]        task_din_req,
    input  logic [NUM_TASKS*DOUT_W-1:0] task_dout,
    input  logic [NUM_TASKS-1:0]        task_dout_valid,
    input  logic [NUM_TASKS-1:0]        task_dout_last,
    output logic [NUM_TASKS-1:0]        task_dout_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [DOUT_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    state_t               state, state_nx;
    logic [NUM_TASKS-1:0] pending, sel;
    logic [4:0]           cur_idx, pe_num;
    logic                 pe_found;
    logic [CNT_W-1:0]     req_cnt, in_cnt, out_cnt;
    logic [31:0]          wdog;
    logic                 out_last;
    task_params_t         prm;
    logic [31:0]          n_req, n_in, n_out;
    logic                 run, req_fire, in_fire, dout_fire, wr_fire;
    logic                 din_req_cur, dout_valid_cur, dout_last_cur;
    logic                 dout_rdy, activity, complete, expire;
    logic [DOUT_W-1:0]    dout_cur;

    task_select_pe #(.N(NUM_TASKS)) u_pe (
        .req      (pending),
        .task_num (pe_num),
        .found    (pe_found)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign prm   = params_of(cur_idx);
    assign n_req = 32'(prm.tv_in_num_transactions);
    assign n_in  = 32'(prm.tv_in_bytes);
    assign n_out = 32'(prm.tv_out_num_transactions);
    assign sel   = NUM_TASKS'(1) << cur_idx;
    assign run   = (state == S_RUN);

    assign din_req_cur    = |(task_din_req & sel);
    assign dout_valid_cur = |(task_dout_valid & sel);
    assign dout_last_cur  = |(task_dout_last & sel);
    assign dout_cur       = DOUT_W'(task_dout >> (32'(cur_idx) * 32'(DOUT_W)));

    assign req_valid = run && (32'(req_cnt) < n_req);
    assign req_addr  = req_valid ? TV_IN_BASE + (ADDR_W'(req_cnt) << 2) : '0;
    assign in_ready  = run && (32'(in_cnt) < n_in) && din_req_cur;

    // Never pull a word beyond the task's quota or past a pending last word.
    assign dout_rdy = run
                    && (!out_valid || (out_ready && !out_last))
                    && (32'(out_cnt) + 32'(out_valid) < n_out);
    assign task_dout_ready = dout_rdy ? sel : '0;

    assign out_addr = TV_OUT_BASE
                    + ADDR_W'(cur_idx) * TV_OUT_STRIDE
                    + (ADDR_W'(out_cnt) << 2);

    assign req_fire  = req_valid && req_ready;
    assign in_fire   = in_valid && in_ready;
    assign dout_fire = dout_valid_cur && dout_rdy;
    assign wr_fire   = out_valid && out_ready;
    assign activity  = req_fire || in_fire || dout_fire || wr_fire;

    assign complete = run && ((32'(out_cnt) >= n_out)
                    || (wr_fire && (out_last || 32'(out_cnt) + 1 >= n_out)));
    assign expire   = run && !activity && (wdog >= 32'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_SELECT;
            S_SELECT: state_nx = pe_found ? S_RUN : S_FINISH;
            S_RUN:    if (complete || expire) state_nx = S_NEXT;
            S_NEXT:   state_nx = S_SELECT;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_task     <= '0;
            cur_idx      <= '0;
            done_mask    <= '0;
            timeout_mask <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    pending      <= task_mask;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    done_mask    <= '0;
                    timeout_mask <= '0;
                end
                S_SELECT: if (pe_found) begin
                    cur_task <= pe_num;
                    cur_idx  <= pe_num - 5'd1;
                end
                S_RUN: begin
                    if (complete)    done_mask    <= done_mask | sel;
                    else if (expire) timeout_mask <= timeout_mask | sel;
                end
                S_NEXT: pending <= pending & ~sel;
                S_FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cur_task <= '0;
                    cur_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_cnt        <= '0;
            in_cnt         <= '0;
            out_cnt        <= '0;
            wdog           <= '0;
            task_din       <= '0;
            task_din_valid <= '0;
            task_din_last  <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else begin
            task_din_valid <= '0;
            task_din_last  <= 1'b0;
            if (state == S_SELECT) begin
                req_cnt   <= '0;
                in_cnt    <= '0;
                out_cnt   <= '0;
                wdog      <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (req_fire) req_cnt <= sat_inc(req_cnt);
            if (in_fire) begin
                in_cnt         <= sat_inc(in_cnt);
                task_din       <= in_data;
                task_din_valid <= sel;
                task_din_last  <= (32'(in_cnt) + 1 == n_in);
            end
            if (run) begin
                if (activity)        wdog <= '0;
                else if (wdog != '1) wdog <= wdog + 32'd1;
            end
            if (wr_fire) begin
                out_cnt   <= sat_inc(out_cnt);
                out_valid <= 1'b0;
            end
            if (dout_fire) begin
                out_valid <= 1'b1;
                out_data  <= dout_cur;
                out_last  <= dout_last_cur;
            end
            // An abandoned task's unsent word is dropped with it.
            if (expire && !complete) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_task_sequencer.sv
// Scoreboard bench for task_sequencer: directed runs push expected
// TV_OUT writes; a monitor pops and compares every accepted write.
module tb_task_sequencer;

    localparam int NT = 16;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start;
    logic [NT-1:0]     task_mask;
    logic              busy, done;
    logic [4:0]        cur_task;
    logic [NT-1:0]     done_mask, timeout_mask;
    logic [31:0]       req_addr;
    logic              req_valid, req_ready;
    logic [7:0]        in_data;
    logic              in_valid, in_ready;
    logic [7:0]        task_din;
    logic [NT-1:0]     task_din_valid;
    logic              task_din_last;
    logic [NT-1:0]     task_din_req;
    logic [NT*32-1:0]  task_dout;
    logic [NT-1:0]     task_dout_valid, task_dout_last, task_dout_ready;
    logic [31:0]       out_addr, out_data;
    logic              out_valid, out_ready;

    always #5 clk = ~clk;

    task_sequencer #(.TIMEOUT(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .start           (start),
        .task_mask       (task_mask),
        .busy            (busy),
        .done            (done),
        .cur_task        (cur_task),
        .done_mask       (done_mask),
        .timeout_mask    (timeout_mask),
        .req_addr        (req_addr),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .task_din        (task_din),
        .task_din_valid  (task_din_valid),
        .task_din_last   (task_din_last),
        .task_din_req    (task_din_req),
        .task_dout       (task_dout),
        .task_dout_valid (task_dout_valid),
        .task_dout_last  (task_dout_last),
        .task_dout_ready (task_dout_ready),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int  nbytes [1:NT];
    int  nwords [1:NT];
    int  last_at[1:NT];
    bit  silent [1:NT];
    int  rcvd   [1:NT];
    int  sent   [1:NT];
    bit  hs_dout[1:NT];
    bit  hs_in;
    bit  toggle_ready;
    int  in_byte;
    int  req_seen;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(int k, int j);
        return 32'hC000_0000 | 32'(k << 8) | 32'(j);
    endfunction

    task automatic expect_task(int k, int n);
        wr_t w;
        for (int j = 0; j < n; j++) begin
            w.addr = 32'hA000_0800 + 32'(k - 1) * 32'h100 + 32'(j * 4);
            w.data = word(k, j);
            exp_q.push_back(w);
        end
    endtask

    // Bench-side copy of the TV geometry table.
    task automatic init_models();
        @(negedge clk);
        #4;
        for (int k = 1; k <= NT; k++) begin
            nbytes[k]  = 4;
            nwords[k]  = 1;
            last_at[k] = -1;
            silent[k]  = 1'b0;
            rcvd[k]    = 0;
            sent[k]    = 0;
            hs_dout[k] = 1'b0;
        end
        nbytes[1] = 8; nwords[1] = 2;
        nbytes[3] = 8; nwords[3] = 2;
        nwords[4] = 4;
        nbytes[5] = 0; nwords[5] = 4;
        hs_in = 1'b0;
        toggle_ready = 1'b0;
    endtask

    task automatic start_run(logic [NT-1:0] m);
        @(negedge clk);
        start = 1'b1;
        task_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int i;
        for (i = 0; i < 400 && !done; i++) @(negedge clk);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Input source and task models, driven on the falling edge.
    initial begin
        bit act;
        in_valid = 1'b1;
        in_data = '0;
        req_ready = 1'b1;
        task_din_req = '1;
        task_dout = '0;
        task_dout_valid = '0;
        task_dout_last = '0;
        out_ready = 1'b1;
        hs_in = 1'b0;
        in_byte = 0;
        req_seen = 0;
        forever begin
            @(negedge clk);
            if (hs_in) in_byte++;
            for (int k = 1; k <= NT; k++) begin
                if (hs_dout[k]) sent[k]++;
                if (task_din_valid[k-1]) rcvd[k]++;
            end
            in_data = 8'(in_byte);
            for (int k = 1; k <= NT; k++) begin
                act = !silent[k] && rcvd[k] >= nbytes[k]
                   && sent[k] < nwords[k];
                task_dout_valid[k-1] = act;
                task_dout[(k-1)*32 +: 32] = word(k, sent[k]);
                task_dout_last[k-1] = (sent[k] == last_at[k]);
            end
            out_ready = toggle_ready ? ~out_ready : 1'b1;
            #2;
            hs_in = in_valid && in_ready;
            if (req_valid) req_seen++;
            for (int k = 1; k <= NT; k++)
                hs_dout[k] = task_dout_valid[k-1] && task_dout_ready[k-1];
        end
    end

    // Write monitor / scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write: addr %0h data %0h, none expected",
                             out_addr, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(out_addr), 64'(e.addr));
                    check("wr_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int seen;
        start = 1'b0;
        task_mask = '0;
        init_models();

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cur_task", 64'(cur_task), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_req_addr", 64'(req_addr), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'hA000_0800);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_din_valid", 64'(task_din_valid), 64'd0);
        check("rst_dout_ready", 64'(task_dout_ready), 64'd0);
        check("rst_masks", 64'({done_mask, timeout_mask}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tasks 1 and 3, out_ready held high.
        expect_task(1, 2);
        expect_task(3, 2);
        start_run(16'h0005);
        check("t1_busy_lat", 64'(busy), 64'd1);
        check("t1_select_no_req", 64'(req_valid), 64'd0);
        @(negedge clk);
        check("t1_req_lat", 64'(req_valid), 64'd1);
        check("t1_req_addr", 64'(req_addr), 64'hA000_0000);
        check("t1_cur_task", 64'(cur_task), 64'd1);
        @(negedge clk);
        check("t1_din_lat", 64'(task_din_valid), 64'h0001);
        wait_done("t1");
        check("t1_done_mask", 64'(done_mask), 64'h0005);
        check("t1_timeout_mask", 64'(timeout_mask), 64'h0000);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_idle_cur", 64'(cur_task), 64'd0);

        // Empty mask.
        seen = req_seen;
        start_run(16'h0000);
        check("m0_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        check("m0_done_c2", 64'(done), 64'd0);
        @(negedge clk);
        check("m0_done_c3", 64'(done), 64'd1);
        check("m0_no_req", 64'(req_seen - seen), 64'd0);
        check("m0_masks", 64'({done_mask, timeout_mask}), 64'd0);

        // Task 2 never answers; task 3 must still run.
        init_models();
        silent[2] = 1'b1;
        expect_task(3, 2);
        start_run(16'h0006);
        wait_done("to");
        check("to_done_mask", 64'(done_mask), 64'h0004);
        check("to_timeout_mask", 64'(timeout_mask), 64'h0002);

        // Back-pressure on a 4-word task; a start while busy is ignored.
        init_models();
        toggle_ready = 1'b1;
        expect_task(4, 4);
        start_run(16'h0008);
        @(negedge clk);
        start_run(16'h0001);
        wait_done("bp");
        check("bp_done_mask", 64'(done_mask), 64'h0008);
        check("bp_timeout_mask", 64'(timeout_mask), 64'h0000);

        // Early last on word 0 of task 4, then zero-input task 5.
        init_models();
        last_at[4] = 0;
        expect_task(4, 1);
        expect_task(5, 4);
        seen = req_seen;
        start_run(16'h0018);
        wait_done("last");
        check("last_done_mask", 64'(done_mask), 64'h0018);
        check("last_timeout_mask", 64'(timeout_mask), 64'h0000);
        check("last_req_count", 64'(req_seen - seen), 64'd1);

        // Asynchronous reset mid-run, then a clean rerun.
        init_models();
        start_run(16'h0005);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_cur_task", 64'(cur_task), 64'd0);
        check("ar_req_valid", 64'(req_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd0);
        check("ar_din_valid", 64'(task_din_valid), 64'd0);
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_addr", 64'(out_addr), 64'hA000_0800);
        exp_q.delete();
        init_models();
        @(negedge clk);
        rst_n = 1'b1;
        expect_task(1, 2);
        expect_task(3, 2);
        start_run(16'h0005);
        wait_done("rerun");
        check("rerun_done_mask", 64'(done_mask), 64'h0005);
        check("rerun_timeout_mask", 64'(timeout_mask), 64'h0000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
